// File: rtl/div_pkg.sv
// Shared types for the divider issue queue: machine widths, queued uop and captured result.
package div_pkg;
  localparam int M_WIDTH        = 64;
  localparam int LG_ROB_ENTRIES = 6;
  localparam int LG_PRF_ENTRIES = 7;

  typedef struct packed {
    logic [M_WIDTH-1:0]        srcA;
    logic [M_WIDTH-1:0]        srcB;
    logic [LG_ROB_ENTRIES-1:0] rob_ptr;
    logic [LG_PRF_ENTRIES-1:0] prf_ptr;
    logic                      is_signed;
    logic                      is_rem;
    logic                      is_w;
  } div_uop_t;

  typedef struct packed {
    logic [M_WIDTH-1:0]        data;
    logic [LG_ROB_ENTRIES-1:0] rob_ptr;
    logic [LG_PRF_ENTRIES-1:0] prf_ptr;
  } div_res_t;
endpackage

// File: rtl/div_uop_fifo.sv
// Circular buffer of divide uops; the caller guarantees no push when full and no pop when empty.
module div_uop_fifo
  import div_pkg::*;
#(
  parameter int LG_N = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_push,
  input  div_uop_t        i_uop,
  input  logic            i_pop,
  input  logic            i_clear,
  output logic [LG_N:0]   o_count,
  output div_uop_t        o_head
);
  localparam int N = 1 << LG_N;

  div_uop_t        r_mem [N];
  logic [LG_N-1:0] r_head;
  logic [LG_N-1:0] r_tail;
  logic [LG_N:0]   r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
    end else if (i_clear) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_uop;
        r_tail        <= r_tail + LG_N'(1);
      end
      if (i_pop) r_head <= r_head + LG_N'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (LG_N+1)'(1);
        2'b01:   r_count <= r_count - (LG_N+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_head];
endmodule

// File: rtl/div_issue_queue.sv
// Divider front end: queues divide uops, launches them one at a time, and holds each
// result until the shared writeback slot is free. Flush discards queued and in-flight work.
module div_issue_queue
  import div_pkg::*;
#(
  parameter int LG_N = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      uop_valid,
  output logic                      uop_ready,
  input  logic [M_WIDTH-1:0]        uop_srcA,
  input  logic [M_WIDTH-1:0]        uop_srcB,
  input  logic [LG_ROB_ENTRIES-1:0] uop_rob_ptr,
  input  logic [LG_PRF_ENTRIES-1:0] uop_prf_ptr,
  input  logic                      uop_is_signed,
  input  logic                      uop_is_rem,
  input  logic                      uop_is_w,
  input  logic                      flush,
  output logic                      div_start,
  output logic [M_WIDTH-1:0]        div_inA,
  output logic [M_WIDTH-1:0]        div_inB,
  output logic [LG_ROB_ENTRIES-1:0] div_rob_ptr,
  output logic [LG_PRF_ENTRIES-1:0] div_prf_ptr,
  output logic                      div_is_signed,
  output logic                      div_is_rem,
  output logic                      div_is_w,
  input  logic                      div_complete,
  input  logic [M_WIDTH-1:0]        div_y,
  input  logic [LG_ROB_ENTRIES-1:0] div_rob_ptr_out,
  input  logic [LG_PRF_ENTRIES-1:0] div_prf_ptr_out,
  input  logic                      wb_slot_used,
  output logic                      wb_valid,
  output logic [M_WIDTH-1:0]        wb_data,
  output logic [LG_ROB_ENTRIES-1:0] wb_rob_ptr,
  output logic [LG_PRF_ENTRIES-1:0] wb_prf_ptr,
  output logic                      busy
);
  localparam int N_ENTRIES = 1 << LG_N;

  logic [LG_N:0] w_count;
  div_uop_t      w_head;
  div_uop_t      w_enq_uop;
  logic          w_push;
  logic          w_head_valid;
  logic          w_wb_fire;
  logic          w_start;
  logic          w_complete;

  logic          r_inflight;
  logic          r_drop;
  logic          r_res_valid;
  div_res_t      r_res;

  assign w_enq_uop = '{srcA: uop_srcA, srcB: uop_srcB, rob_ptr: uop_rob_ptr,
                       prf_ptr: uop_prf_ptr, is_signed: uop_is_signed,
                       is_rem: uop_is_rem, is_w: uop_is_w};

  assign uop_ready    = (w_count != (LG_N+1)'(N_ENTRIES));
  assign w_push       = uop_valid & uop_ready & ~flush;
  assign w_head_valid = (w_count != '0);
  assign w_complete   = div_complete & r_inflight;

  // A held result draining this cycle frees the buffer for the next launch.
  assign w_wb_fire = r_res_valid & ~wb_slot_used & ~flush;
  assign w_start   = w_head_valid & ~r_inflight & ~flush & (~r_res_valid | w_wb_fire);

  div_uop_fifo #(.LG_N(LG_N)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_uop   (w_enq_uop),
    .i_pop   (w_start),
    .i_clear (flush),
    .o_count (w_count),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inflight  <= 1'b0;
      r_drop      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res       <= '0;
    end else begin
      if (w_wb_fire) r_res_valid <= 1'b0;
      if (w_start)   r_inflight  <= 1'b1;
      if (w_complete) begin
        r_inflight <= 1'b0;
        if (r_drop || flush) begin
          r_drop <= 1'b0;
        end else begin
          r_res_valid <= 1'b1;
          r_res       <= '{data: div_y, rob_ptr: div_rob_ptr_out, prf_ptr: div_prf_ptr_out};
        end
      end else if (flush && r_inflight) begin
        // The launched divide cannot be recalled, so its result is marked for discard.
        r_drop <= 1'b1;
      end
      if (flush) r_res_valid <= 1'b0;
    end
  end

  assign div_start     = w_start;
  assign div_inA       = w_head.srcA;
  assign div_inB       = w_head.srcB;
  assign div_rob_ptr   = w_head.rob_ptr;
  assign div_prf_ptr   = w_head.prf_ptr;
  assign div_is_signed = w_head.is_signed;
  assign div_is_rem    = w_head.is_rem;
  assign div_is_w      = w_head.is_w;

  assign wb_valid   = w_wb_fire;
  assign wb_data    = r_res.data;
  assign wb_rob_ptr = r_res.rob_ptr;
  assign wb_prf_ptr = r_res.prf_ptr;

  assign busy = w_head_valid | r_inflight | r_res_valid;
endmodule
